// File: rtl/fir_pkg.sv
// Shared types and constants for the fir_mac_pipe block.
package fir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fir_state_e;

  localparam int unsigned FIR_DATA_W = 8;
  localparam int unsigned FIR_TAPS   = 7;

  function automatic int unsigned fir_clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    if (value > 1) begin
      v = value - 1;
      while (v != 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mult_stage.sv
// Stage 1 of the FIR MAC pipe: registered signed multiply plus beat tags.
module fir_mult_stage
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int ACC_W  = 2 * FIR_DATA_W + 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] coef,
  output logic                     s1_valid,
  output logic                     s1_first,
  output logic                     s1_last,
  output logic signed [ACC_W-1:0]  s1_prod
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(sample) * (2*DATA_W)'(coef);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_valid & in_first;
      s1_last  <= in_valid & in_last;
      if (in_valid) s1_prod <= ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_pipe.sv
// Two-stage FIR multiply-accumulate: tap control, stage 2 accumulator, result register.
// Define FIR_MAC_SAT_EN to clamp every stage-2 load/add instead of wrapping.
module fir_mac_pipe
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int TAPS   = FIR_TAPS,
  parameter int ACC_W  = 2 * DATA_W + 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] coef,
  output logic signed [ACC_W-1:0]  y,
  output logic                     valid_out,
  output logic                     abort
);

  localparam int CNT_W = (fir_clog2(TAPS) > 0) ? int'(fir_clog2(TAPS)) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  fir_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tag_valid, tag_first, tag_last, abort_n;

  logic                    s1_valid, s1_first, s1_last;
  logic signed [ACC_W-1:0] s1_prod;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic                    done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      abort <= abort_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tag_valid = 1'b0;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    abort_n   = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        tag_valid = 1'b1;
        tag_first = 1'b1;
        abort_n   = (state == ACCUM);
        if (TAPS == 1) begin
          tag_last = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end else begin
          state_n = ACCUM;
          cnt_n   = CNT_W'(1);
        end
      end else if (state == ACCUM) begin
        tag_valid = 1'b1;
        if (cnt == LAST_CNT) begin
          tag_last = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
  end

  fir_mult_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mult (
    .clock    (clock),
    .reset    (reset),
    .in_valid (tag_valid),
    .in_first (tag_first),
    .in_last  (tag_last),
    .sample   (sample),
    .coef     (coef),
    .s1_valid (s1_valid),
    .s1_first (s1_first),
    .s1_last  (s1_last),
    .s1_prod  (s1_prod)
  );

`ifdef FIR_MAC_SAT_EN
  logic signed [ACC_W:0] wide;

  always_comb begin
    wide = s1_first ? {s1_prod[ACC_W-1], s1_prod}
                    : ({acc[ACC_W-1], acc} + {s1_prod[ACC_W-1], s1_prod});
    // Overflow shows as disagreement between the guard bit and the ACC_W sign bit.
    if (wide[ACC_W] != wide[ACC_W-1])
      acc_n = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_n = wide[ACC_W-1:0];
  end
`else
  assign acc_n = s1_first ? s1_prod : acc + s1_prod;
`endif

  // y is loaded from acc one edge after the last add, so a following first beat may reload acc freely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      done      <= 1'b0;
      y         <= '0;
      valid_out <= 1'b0;
    end else begin
      if (s1_valid) acc <= acc_n;
      done      <= s1_valid & s1_last;
      valid_out <= done;
      if (done) y <= acc;
    end
  end

endmodule

// File: doc/fir_mac_pipe.md
FIR_MAC_PIPE -- requirements
Module: fir_mac_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed sample and coefficient width.
REQ-002 SHALL have parameter TAPS, default 7: products per output sum, legal range 1..256.
REQ-003 SHALL have parameter ACC_W, default 2*DATA_W+3: accumulator and output width, legal range 2*DATA_W..64.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  sample/coef beat present this cycle; always accepted, no backpressure.
REQ-007 SHALL have port in_first  in  1  beat is tap 0 of a new sum; ignored when in_valid=0.
REQ-008 SHALL have port sample  in  DATA_W  signed two's-complement data.
REQ-009 SHALL have port coef  in  DATA_W  signed two's-complement coefficient.
REQ-010 SHALL have port y  out  ACC_W  signed result, held until next result.
REQ-011 SHALL have port valid_out  out  1  one-cycle pulse, y newly valid.
REQ-012 SHALL have port abort  out  1  one-cycle pulse, partial sum discarded.

Function
REQ-013 SHALL form sample*coef as a signed 2*DATA_W product, sign-extended to ACC_W.
REQ-014 SHALL use a 2-stage pipeline: stage 1 registers product plus first/last tags; stage 2 accumulates.
REQ-015 SHALL keep states IDLE and ACCUM plus a tap counter of clog2(TAPS) bits (minimum 1).
REQ-016 IDLE: beat with in_first=1 -> tap 0; go to ACCUM (stay IDLE if TAPS=1); beat with in_first=0 is dropped, no state change.
REQ-017 ACCUM: beat with in_first=0 increments counter; beat at counter=TAPS-1 is tagged last; counter clears, state -> IDLE.
REQ-018 ACCUM: beat with in_first=1 discards the partial sum, pulses abort on the next edge, restarts as tap 0.
REQ-019 Stage 2: first-tagged product loads acc; others add to acc.
REQ-020 Last beat sampled on edge N -> y = full sum and valid_out=1 after edge N+2; valid_out low after N+3 unless another sum completes.
REQ-021 in_valid=0 cycles SHALL stall the sum without loss; gaps of any length are allowed.
REQ-022 Back-to-back sums (in_first on the beat after a last beat) SHALL need no bubble; continuous input yields one valid_out every TAPS cycles.
REQ-023 TAPS=1: every in_first beat is both first and last; every such beat yields valid_out.
REQ-024 Without FIR_MAC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W.

Reset
REQ-025 reset=1 SHALL immediately force y=0, valid_out=0, abort=0, counter=0, state IDLE, and clear stage-1 valid and tags.
REQ-026 Reset mid-sum SHALL discard the in-flight sum with no valid_out or abort pulse; after release, input is dropped until an in_first beat.

Configuration
REQ-027 Macro FIR_MAC_SAT_EN defined: each stage-2 add/load SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamping is sticky per add only, with no extra port.
REQ-028 Macro FIR_MAC_SAT_EN undefined: no saturation logic; wrap per REQ-024.

Structure
REQ-029 Package fir_pkg SHALL hold the IDLE/ACCUM state typedef, default DATA_W/TAPS constants and a clog2 function.
REQ-030 Sub-module fir_mult_stage SHALL implement stage 1 (registered signed multiply plus first/last/valid tags); fir_mac_pipe holds control and stage 2.

Verification
REQ-031 DATA_W=8, TAPS=7, ACC_W=19: samples 1..7, coef=2, in_valid continuous -> y=56, valid_out for exactly 1 cycle, 2 edges after the last beat.
REQ-032 Signed: 7 beats of sample=-128, coef=127 -> y=-113792; then immediate next sum, 7 beats of 1*1 -> y=7 exactly 7 cycles later.
REQ-033 ACC_W=16, 7 beats of -128*-128 -> y=32767 with FIR_MAC_SAT_EN, y=-16384 (wrap of 114688) without.
REQ-034 in_first re-asserted at tap 3, then 7 beats of 1*3 -> abort pulses once, y=21, no valid_out for the aborted sum.
REQ-035 Samples 1..7, coef=1, with in_valid=0 gaps of 0-3 random cycles -> y=28; beats with in_first=0 while IDLE have no effect.
REQ-036 reset asserted asynchronously after tap 4 -> outputs 0 immediately; no valid_out until a fresh 7-beat sum completes.
